// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: packet type codes, source-select and scheduler state types
package hdmi_packet_pkg;
  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AINFO = 8'h84;
  typedef enum logic [2:0] {SRC_NULL, SRC_ACR, SRC_AUDIO, SRC_AVI, SRC_AINFO} src_t;
  typedef enum logic {S_IDLE, S_SEND} state_t;
  function automatic logic [7:0] pkt_type(src_t s);
    return s == SRC_ACR ? PKT_ACR : s == SRC_AUDIO ? PKT_AUDIO :
           s == SRC_AVI ? PKT_AVI : s == SRC_AINFO ? PKT_AINFO : PKT_NULL;
  endfunction
endpackage

// File: rtl/packet_pending_tracker.sv
// packet_pending_tracker: set-wins pending flag with coalesce pulse and optional toggle-edge set
module packet_pending_tracker #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_pixel,
  input  logic reset_n,
  input  logic set_in,
  input  logic clr,
  output logic pend,
  output logic drop
);
  logic prev;
  logic ev;
  assign ev = EDGE ? set_in ^ prev : set_in;
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
      pend <= 1'b0;
      drop <= 1'b0;
    end else begin
      prev <= set_in;
      pend <= ev | (pend & ~clr);
      drop <= ev & pend;
    end
  end
endmodule

// File: rtl/data_island_packet_scheduler.sv
// data_island_packet_scheduler: picks the packet for each data island slot and holds it for the slot
module data_island_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int PACKET_CYCLES    = 32,
  parameter int INFOFRAME_PERIOD = 1
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         packet_slot,
  input  logic         frame_start,
  input  logic         acr_wrap,
  input  logic         audio_pending,
  input  logic [23:0]  acr_header,
  input  logic [23:0]  audio_header,
  input  logic [23:0]  avi_header,
  input  logic [23:0]  ainfo_header,
  input  logic [223:0] acr_sub,
  input  logic [223:0] audio_sub,
  input  logic [223:0] avi_sub,
  input  logic [223:0] ainfo_sub,
  output logic [23:0]  header,
  output logic [223:0] sub,
  output logic [7:0]   packet_type,
  output logic         busy,
  output logic         audio_ack,
  output logic         acr_drop,
  output logic         slot_overlap
);
  localparam int CW = $clog2(PACKET_CYCLES);
  localparam int FW = INFOFRAME_PERIOD > 1 ? $clog2(INFOFRAME_PERIOD) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt;
  logic acr_p, avi_p, ainfo_p, info_set, load;
  logic avi_drop_unused, ainfo_drop_unused;
  src_t sel;
  logic [23:0] hdr_sel;
  logic [223:0] sub_sel;
  always_comb begin
    sel = acr_p ? SRC_ACR : audio_pending ? SRC_AUDIO : avi_p ? SRC_AVI :
          ainfo_p ? SRC_AINFO : SRC_NULL;
    hdr_sel = sel == SRC_ACR ? acr_header : sel == SRC_AUDIO ? audio_header :
              sel == SRC_AVI ? avi_header : sel == SRC_AINFO ? ainfo_header : '0;
    sub_sel = sel == SRC_ACR ? acr_sub : sel == SRC_AUDIO ? audio_sub :
              sel == SRC_AVI ? avi_sub : sel == SRC_AINFO ? ainfo_sub : '0;
  end
  assign load = state == S_IDLE && packet_slot;
  assign info_set = frame_start && frame_cnt == '0;
  packet_pending_tracker #(.EDGE(1'b1)) u_acr (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .set_in(acr_wrap),
    .clr(load && sel == SRC_ACR), .pend(acr_p), .drop(acr_drop)
  );
  packet_pending_tracker #(.EDGE(1'b0)) u_avi (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .set_in(info_set),
    .clr(load && sel == SRC_AVI), .pend(avi_p), .drop(avi_drop_unused)
  );
  packet_pending_tracker #(.EDGE(1'b0)) u_ainfo (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .set_in(info_set),
    .clr(load && sel == SRC_AINFO), .pend(ainfo_p), .drop(ainfo_drop_unused)
  );
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt == FW'(INFOFRAME_PERIOD - 1) ? '0 : frame_cnt + 1'b1;
  end
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      header       <= '0;
      sub          <= '0;
      packet_type  <= '0;
      busy         <= 1'b0;
      audio_ack    <= 1'b0;
      slot_overlap <= 1'b0;
    end else begin
      audio_ack    <= 1'b0;
      slot_overlap <= 1'b0;
      if (state == S_IDLE) begin
        if (packet_slot) begin
          state       <= S_SEND;
          cnt         <= CW'(PACKET_CYCLES - 1);
          busy        <= 1'b1;
          header      <= hdr_sel;
          sub         <= sub_sel;
          packet_type <= pkt_type(sel);
          audio_ack   <= sel == SRC_AUDIO;
        end
      end else begin
        slot_overlap <= packet_slot;
        cnt          <= cnt - 1'b1;
        if (cnt == '0) begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          header      <= '0;
          sub         <= '0;
          packet_type <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// tb_data_island_packet_scheduler: directed plus randomized checks against a slot-level model
module tb_data_island_packet_scheduler;
  localparam int PC = 32;
  localparam int IP = 2;
  logic clk_pixel = 1'b0, reset_n = 1'b0, packet_slot = 1'b0, frame_start = 1'b0;
  logic acr_wrap = 1'b0, audio_pending = 1'b0;
  logic [23:0] acr_header, audio_header, avi_header, ainfo_header, header;
  logic [223:0] acr_sub, audio_sub, avi_sub, ainfo_sub, sub;
  logic [7:0] packet_type;
  logic busy, audio_ack, acr_drop, slot_overlap;
  int errors = 0, checks = 0;
  bit acr_m, avi_m, ainfo_m;
  int fc;

  data_island_packet_scheduler #(.PACKET_CYCLES(PC), .INFOFRAME_PERIOD(IP)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_slot(packet_slot),
    .frame_start(frame_start), .acr_wrap(acr_wrap), .audio_pending(audio_pending),
    .acr_header(acr_header), .audio_header(audio_header), .avi_header(avi_header),
    .ainfo_header(ainfo_header), .acr_sub(acr_sub), .audio_sub(audio_sub),
    .avi_sub(avi_sub), .ainfo_sub(ainfo_sub), .header(header), .sub(sub),
    .packet_type(packet_type), .busy(busy), .audio_ack(audio_ack),
    .acr_drop(acr_drop), .slot_overlap(slot_overlap)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [223:0] rnd_sub();
    logic [223:0] r = '0;
    for (int k = 0; k < 7; k++) r = {r[191:0], 32'($urandom)};
    return r;
  endfunction

  task automatic randomize_src();
    acr_header = 24'($urandom); audio_header = 24'($urandom);
    avi_header = 24'($urandom); ainfo_header = 24'($urandom);
    acr_sub = rnd_sub(); audio_sub = rnd_sub(); avi_sub = rnd_sub(); ainfo_sub = rnd_sub();
  endtask

  task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".header"}, header, 0);
    chk({tag, ".sub"}, sub, 0);
    chk({tag, ".type"}, packet_type, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".ack"}, audio_ack, 0);
    chk({tag, ".drop"}, acr_drop, 0);
    chk({tag, ".overlap"}, slot_overlap, 0);
  endtask

  task automatic toggle_acr();
    acr_wrap = ~acr_wrap;
    @(negedge clk_pixel);
    chk("acr_drop", acr_drop, acr_m);
    acr_m = 1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk_pixel);
    frame_start = 1'b0;
    if (fc == 0) begin avi_m = 1; ainfo_m = 1; end
    fc = (fc + 1) % IP;
  endtask

  task automatic do_slot(input int ov, input int rst_at);
    logic [23:0] eh = '0;
    logic [223:0] es = '0;
    logic [7:0] et = 8'h00;
    bit ack = 0;
    if (acr_m) begin eh = acr_header; es = acr_sub; et = 8'h01; acr_m = 0; end
    else if (audio_pending) begin eh = audio_header; es = audio_sub; et = 8'h02; ack = 1; end
    else if (avi_m) begin eh = avi_header; es = avi_sub; et = 8'h82; avi_m = 0; end
    else if (ainfo_m) begin eh = ainfo_header; es = ainfo_sub; et = 8'h84; ainfo_m = 0; end
    packet_slot = 1'b1;
    @(negedge clk_pixel);
    packet_slot = 1'b0;
    randomize_src();
    chk("t1.busy", busy, 1);
    chk("t1.type", packet_type, et);
    chk("t1.header", header, eh);
    chk("t1.sub", sub, es);
    chk("t1.ack", audio_ack, ack);
    for (int i = 2; i <= PC; i++) begin
      @(negedge clk_pixel);
      if (rst_at == i) begin
        reset_n = 1'b0;
        acr_wrap = 1'b0;
        #1;
        chk_zero("async_rst");
        acr_m = 0; avi_m = 0; ainfo_m = 0; fc = 0;
        return;
      end
      if (ov != 0 && i == ov + 1) begin
        packet_slot = 1'b0;
        chk("overlap", slot_overlap, 1);
      end else chk("no_overlap", slot_overlap, 0);
      chk("hold.busy", busy, 1);
      chk("hold.type", packet_type, et);
      chk("hold.header", header, eh);
      chk("hold.sub", sub, es);
      chk("hold.ack", audio_ack, 0);
      if (i == ov) packet_slot = 1'b1;
    end
    @(negedge clk_pixel);
    chk("end.busy", busy, 0);
    chk("end.header", header, 0);
    chk("end.type", packet_type, 0);
  endtask

  initial begin
    randomize_src();
    acr_m = 0; avi_m = 0; ainfo_m = 0; fc = 0;
    @(negedge clk_pixel);
    chk_zero("reset");
    @(negedge clk_pixel);
    reset_n = 1'b1;
    @(negedge clk_pixel);
    do_slot(0, 0);
    toggle_acr();
    audio_pending = 1'b1;
    do_slot(0, 0);
    do_slot(0, 0);
    audio_pending = 1'b0;
    for (int f = 0; f < 4; f++) begin
      frame();
      for (int s = 0; s < 3; s++) do_slot(0, 0);
    end
    toggle_acr();
    toggle_acr();
    do_slot(0, 0);
    do_slot(0, 0);
    audio_pending = 1'b1;
    do_slot(10, 0);
    audio_pending = 1'b0;
    toggle_acr();
    do_slot(0, 5);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    @(negedge clk_pixel);
    do_slot(0, 0);
    for (int r = 0; r < 20; r++) begin
      audio_pending = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) toggle_acr();
      if ($urandom_range(0, 1) == 0) toggle_acr();
      if ($urandom_range(0, 3) == 0) frame();
      randomize_src();
      do_slot($urandom_range(0, 1) != 0 ? int'($urandom_range(2, PC - 1)) : 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
